// File: rtl/cdr_lf_pkg.sv
// -----------------------------------------------------------------------------
// cdr_lf_pkg
//   Shared types and defaults for the CDR digital loop filter.
//   - lf_mode_e      : loop operating mode (mode code 3 behaves as LF_FREEZE)
//   - *_DEF          : default parameter values for cdr_loop_filter
//   - clamp_shift()  : limits a gain shift so 1<<shift stays below full scale
//   - mode_is_freeze(): decodes both freeze encodings
// -----------------------------------------------------------------------------
package cdr_lf_pkg;

   typedef enum logic [1:0] {
      LF_2ND    = 2'd0,
      LF_1ST    = 2'd1,
      LF_FREEZE = 2'd2
   } lf_mode_e;

   localparam int NUM_PD_DEF      = 4;
   localparam int DEC_LEN_DEF     = 4;
   localparam int FREQ_WIDTH_DEF  = 16;
   localparam int PHASE_WIDTH_DEF = 25;
   localparam int CODE_WIDTH_DEF  = 11;
   localparam int FSHIFT_DEF      = 6;
   localparam int LOCK_CNT_DEF    = 64;

   // A shift of fw-1 or more would push the step onto the sign bit of the
   // frequency word, so such settings fall back to the largest legal shift.
   function automatic logic [3:0] clamp_shift(input logic [3:0] sh, input int fw);
      if (int'(sh) >= fw - 1) begin
         return 4'(fw - 2);
      end
      return sh;
   endfunction

   function automatic logic mode_is_freeze(input logic [1:0] m);
      return m[1];
   endfunction

endpackage

// File: rtl/cdr_lf_vote.sv
// -----------------------------------------------------------------------------
// cdr_lf_vote
//   Per-lane early/late vote and its pipeline register.
//   Each lane contributes +1 (up only), -1 (dn only) or 0 (both/neither);
//   the signed lane sum is registered into vote_q.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   up, dn      : NUM_PD lane indications
//   vote_q      : registered signed vote sum
// -----------------------------------------------------------------------------
module cdr_lf_vote #(
   parameter int NUM_PD = 4,
   parameter int VOTE_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_PD-1:0]        up,
   input  logic [NUM_PD-1:0]        dn,
   output logic signed [VOTE_W-1:0] vote_q
);

   localparam logic signed [VOTE_W-1:0] ONE = VOTE_W'(1);

   logic signed [VOTE_W-1:0] vote;

   always_comb begin
      vote = '0;
      for (int i = 0; i < NUM_PD; i++) begin
         if (up[i] && !dn[i]) begin
            vote = vote + ONE;
         end else if (dn[i] && !up[i]) begin
            vote = vote - ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vote_q <= '0;
      end else begin
         vote_q <= vote;
      end
   end

endmodule

// File: rtl/cdr_loop_filter.sv
// -----------------------------------------------------------------------------
// cdr_loop_filter
//   Second-order bang-bang CDR loop filter. Lane votes are summed over a
//   DEC_LEN-cycle window; the sign of each window drives a saturating
//   frequency integrator and a wrapping phase accumulator whose top bits
//   form the phase-interpolator code. A lock counter tracks dithering.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   up, dn       : NUM_PD phase-detector lane pairs
//   kp, ki       : proportional / integral gain shifts
//   mode         : 0 second-order, 1 first-order (freq held), 2/3 freeze
//   clr_sat      : clears sat_flag (a same-cycle set wins)
//   code         : phase-interpolator code (top bits of phase)
//   freq_out     : signed frequency integrator
//   upd_valid    : one-cycle pulse after each integrator update
//   locked       : lock counter at LOCK_CNT
//   sat_flag     : sticky frequency clamp indicator
// -----------------------------------------------------------------------------
module cdr_loop_filter
   import cdr_lf_pkg::*;
#(
   parameter int NUM_PD      = NUM_PD_DEF,
   parameter int DEC_LEN     = DEC_LEN_DEF,
   parameter int FREQ_WIDTH  = FREQ_WIDTH_DEF,
   parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
   parameter int CODE_WIDTH  = CODE_WIDTH_DEF,
   parameter int FSHIFT      = FSHIFT_DEF,
   parameter int LOCK_CNT    = LOCK_CNT_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_PD-1:0]             up,
   input  logic [NUM_PD-1:0]             dn,
   input  logic [3:0]                    kp,
   input  logic [3:0]                    ki,
   input  logic [1:0]                    mode,
   input  logic                          clr_sat,
   output logic [CODE_WIDTH-1:0]         code,
   output logic signed [FREQ_WIDTH-1:0]  freq_out,
   output logic                          upd_valid,
   output logic                          locked,
   output logic                          sat_flag
);

   localparam int VOTE_W = $clog2(NUM_PD + 1) + 1;
   localparam int ACC_W  = $clog2(NUM_PD * DEC_LEN + 1) + 1;
   localparam int CNT_W  = (DEC_LEN > 1) ? $clog2(DEC_LEN) : 1;
   localparam int LOCK_W = $clog2(LOCK_CNT + 1);

   localparam logic [CNT_W-1:0]           WIN_LAST = CNT_W'(DEC_LEN - 1);
   localparam logic [LOCK_W-1:0]          LOCK_TOP = LOCK_W'(LOCK_CNT);
   localparam logic signed [FREQ_WIDTH-1:0] FREQ_MAX = {1'b0, {(FREQ_WIDTH-1){1'b1}}};
   localparam logic signed [FREQ_WIDTH-1:0] FREQ_MIN = {1'b1, {(FREQ_WIDTH-1){1'b0}}};

   logic signed [VOTE_W-1:0]     vote_q;
   logic signed [ACC_W-1:0]      acc;
   logic signed [ACC_W-1:0]      acc_sum;
   logic [CNT_W-1:0]             win_cnt;
   logic                         run_q;
   logic signed [FREQ_WIDTH-1:0] freq;
   logic [PHASE_WIDTH-1:0]       phase;
   logic                         prev_pos;
   logic                         prev_neg;
   logic [LOCK_W-1:0]            lock_cnt;

   logic                         frz;
   logic                         active;
   logic                         win_end;
   logic                         d_pos;
   logic                         d_neg;
   logic [3:0]                   kp_eff;
   logic [3:0]                   ki_eff;
   logic signed [FREQ_WIDTH:0]   freq_ext;
   logic signed [FREQ_WIDTH:0]   ki_step;
   logic signed [FREQ_WIDTH:0]   freq_sum;
   logic                         clamp;
   logic signed [FREQ_WIDTH-1:0] freq_new;
   logic [PHASE_WIDTH-1:0]       freq_term;
   logic [PHASE_WIDTH-1:0]       kp_step;
   logic [PHASE_WIDTH-1:0]       phase_nxt;
   logic [LOCK_W-1:0]            lock_nxt;
   logic                         sat_set;

   cdr_lf_vote #(
      .NUM_PD (NUM_PD),
      .VOTE_W (VOTE_W)
   ) u_vote (
      .clk    (clk),
      .rst_n  (rst_n),
      .up     (up),
      .dn     (dn),
      .vote_q (vote_q)
   );

   always_comb begin
      frz = mode_is_freeze(mode);
      // run_q is low on the first edge after reset or freeze, so every
      // window consumes DEC_LEN votes registered while the loop was running.
      active  = run_q && !frz;
      win_end = active && (win_cnt == WIN_LAST);

      acc_sum = acc + ACC_W'(vote_q);
      d_neg   = acc_sum[ACC_W-1];
      d_pos   = !acc_sum[ACC_W-1] && (acc_sum != '0);

      kp_eff = clamp_shift(kp, FREQ_WIDTH);
      ki_eff = clamp_shift(ki, FREQ_WIDTH);

      // One guard bit detects overflow of the signed frequency update.
      freq_ext = (FREQ_WIDTH+1)'(freq);
      ki_step  = (FREQ_WIDTH+1)'(1) << ki_eff;
      freq_sum = freq_ext;
      if (d_pos) begin
         freq_sum = freq_ext + ki_step;
      end else if (d_neg) begin
         freq_sum = freq_ext - ki_step;
      end
      clamp = (freq_sum[FREQ_WIDTH] != freq_sum[FREQ_WIDTH-1]);
      if (clamp) begin
         freq_new = freq_sum[FREQ_WIDTH] ? FREQ_MIN : FREQ_MAX;
      end else begin
         freq_new = freq_sum[FREQ_WIDTH-1:0];
      end

      // Phase uses the pre-update frequency; the sum wraps by width.
      freq_term = PHASE_WIDTH'(freq >>> FSHIFT);
      kp_step   = PHASE_WIDTH'(1) << kp_eff;
      phase_nxt = phase + freq_term;
      if (d_pos) begin
         phase_nxt = phase + freq_term + kp_step;
      end else if (d_neg) begin
         phase_nxt = phase + freq_term - kp_step;
      end

      // Zero or alternating decisions count toward lock; a repeat resets it.
      lock_nxt = lock_cnt;
      if ((!d_pos && !d_neg) || (d_pos && prev_neg) || (d_neg && prev_pos)) begin
         if (lock_cnt != LOCK_TOP) begin
            lock_nxt = lock_cnt + LOCK_W'(1);
         end
      end else if ((d_pos && prev_pos) || (d_neg && prev_neg)) begin
         lock_nxt = '0;
      end

      sat_set = win_end && (mode == LF_2ND) && clamp;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         win_cnt   <= '0;
         run_q     <= 1'b0;
         freq      <= '0;
         phase     <= '0;
         prev_pos  <= 1'b0;
         prev_neg  <= 1'b0;
         lock_cnt  <= '0;
         upd_valid <= 1'b0;
         locked    <= 1'b0;
         sat_flag  <= 1'b0;
      end else begin
         run_q     <= !frz;
         upd_valid <= win_end;

         if (sat_set) begin
            sat_flag <= 1'b1;
         end else if (clr_sat) begin
            sat_flag <= 1'b0;
         end

         if (!active) begin
            acc     <= '0;
            win_cnt <= '0;
         end else if (win_end) begin
            acc      <= '0;
            win_cnt  <= '0;
            if (mode == LF_2ND) begin
               freq <= freq_new;
            end
            phase    <= phase_nxt;
            lock_cnt <= lock_nxt;
            locked   <= (lock_nxt == LOCK_TOP);
            if (d_pos || d_neg) begin
               prev_pos <= d_pos;
               prev_neg <= d_neg;
            end
         end else begin
            acc     <= acc_sum;
            win_cnt <= win_cnt + CNT_W'(1);
         end
      end
   end

   assign code     = phase[PHASE_WIDTH-1 -: CODE_WIDTH];
   assign freq_out = freq;

endmodule

// File: tb/tb_cdr_loop_filter.sv
// -----------------------------------------------------------------------------
// tb_cdr_loop_filter
//   Self-checking bench for cdr_loop_filter with default parameters.
//   A window-level integer model is stepped on every rising edge and all
//   outputs are compared 1 ns later; table vectors and directed sequences
//   add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_cdr_loop_filter;

   localparam int  NUM_PD   = 4;
   localparam int  DEC_LEN  = 4;
   localparam int  FSHIFT   = 6;
   localparam int  LOCK_CNT = 64;
   localparam longint PMOD  = longint'(1) << 25;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [3:0]        up = '0;
   logic [3:0]        dn = '0;
   logic [3:0]        kp = 4'd3;
   logic [3:0]        ki = 4'd2;
   logic [1:0]        mode = 2'd0;
   logic              clr_sat = 1'b0;
   logic [10:0]       code;
   logic signed [15:0] freq_out;
   logic              upd_valid;
   logic              locked;
   logic              sat_flag;

   int checks = 0;
   int failures = 0;

   cdr_loop_filter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .up        (up),
      .dn        (dn),
      .kp        (kp),
      .ki        (ki),
      .mode      (mode),
      .clr_sat   (clr_sat),
      .code      (code),
      .freq_out  (freq_out),
      .upd_valid (upd_valid),
      .locked    (locked),
      .sat_flag  (sat_flag)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int     m_freq;
   longint m_phase;
   int     m_lock;
   int     m_prev_d;
   bit     m_sat;
   bit     m_upd;
   bit     m_run;
   int     m_vote_reg;
   int     m_win[$];

   function automatic int vote_of(input logic [3:0] u, input logic [3:0] d);
      int v = 0;
      for (int i = 0; i < NUM_PD; i++) begin
         if (u[i] && !d[i]) v++;
         else if (d[i] && !u[i]) v--;
      end
      return v;
   endfunction

   function automatic int eff_shift(input logic [3:0] s);
      return (int'(s) >= 15) ? 14 : int'(s);
   endfunction

   task automatic model_reset();
      m_freq = 0; m_phase = 0; m_lock = 0; m_prev_d = 0;
      m_sat = 0; m_upd = 0; m_run = 0; m_vote_reg = 0;
      m_win.delete();
   endtask

   task automatic model_edge();
      int     sum;
      int     d;
      int     nf;
      longint delta;
      bit     set_now;
      set_now = 0;
      m_upd = 0;
      if (int'(mode) < 2) begin
         if (m_run) begin
            m_win.push_back(m_vote_reg);
            if (m_win.size() == DEC_LEN) begin
               sum = 0;
               foreach (m_win[j]) sum += m_win[j];
               d = (sum > 0) ? 1 : (sum < 0) ? -1 : 0;
               delta = longint'(m_freq >>> FSHIFT) + longint'(d * (1 << eff_shift(kp)));
               m_phase = ((m_phase + delta) % PMOD + PMOD) % PMOD;
               if (mode == 2'd0) begin
                  nf = m_freq + d * (1 << eff_shift(ki));
                  if (nf > 32767) begin nf = 32767; set_now = 1; end
                  if (nf < -32768) begin nf = -32768; set_now = 1; end
                  m_freq = nf;
               end
               if (d == 0 || d == -m_prev_d) begin
                  if (m_lock < LOCK_CNT) m_lock++;
               end else if (d == m_prev_d) begin
                  m_lock = 0;
               end
               if (d != 0) m_prev_d = d;
               m_upd = 1;
               m_win.delete();
            end
         end
         m_run = 1;
      end else begin
         m_win.delete();
         m_run = 0;
      end
      if (set_now) m_sat = 1;
      else if (clr_sat) m_sat = 0;
      m_vote_reg = vote_of(up, dn);
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("upd_valid", longint'(upd_valid), longint'(m_upd));
      check("freq_out", longint'(freq_out), longint'(m_freq));
      check("code", longint'(code), m_phase >> 14);
      check("locked", longint'(locked), longint'(m_lock == LOCK_CNT));
      check("sat_flag", longint'(sat_flag), longint'(m_sat));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   // Asserts reset away from a clock edge, holds it for two edges, then
   // releases it 1 ns after an edge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;
   endtask

   task automatic count_to_upd(output int n);
      n = 0;
      for (int c = 1; c <= 64; c++) begin
         cyc();
         if (upd_valid) begin
            n = c;
            break;
         end
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0] up;
      logic [3:0] dn;
      logic [3:0] kp;
      logic [3:0] ki;
      int         windows;
      int         exp_freq;
      int         exp_code;
      bit         exp_locked;
      bit         exp_sat;
   } vec_t;

   vec_t tbl[14];

   initial begin
      int n;
      int prev_code;
      int nwin;
      bit wrapped;
      int bias;
      int r;

      tbl[0]  = '{4'hF, 4'h0, 4'd3,  4'd2,  1,      4,    0, 1'b0, 1'b0};
      tbl[1]  = '{4'hF, 4'h0, 4'd3,  4'd2,  2,      8,    0, 1'b0, 1'b0};
      tbl[2]  = '{4'h0, 4'hF, 4'd3,  4'd2,  3,    -12, 2047, 1'b0, 1'b0};
      tbl[3]  = '{4'h3, 4'hC, 4'd3,  4'd2,  64,     0,    0, 1'b1, 1'b0};
      tbl[4]  = '{4'h3, 4'hC, 4'd3,  4'd2,  63,     0,    0, 1'b0, 1'b0};
      tbl[5]  = '{4'hF, 4'h0, 4'd3,  4'd15, 2,  32767,    0, 1'b0, 1'b1};
      tbl[6]  = '{4'hF, 4'h0, 4'd3,  4'd14, 1,  16384,    0, 1'b0, 1'b0};
      tbl[7]  = '{4'h0, 4'hF, 4'd3,  4'd14, 2, -32768, 2047, 1'b0, 1'b0};
      tbl[8]  = '{4'h0, 4'hF, 4'd3,  4'd14, 3, -32768, 2047, 1'b0, 1'b1};
      tbl[9]  = '{4'hF, 4'h0, 4'd14, 4'd0,  2,      2,    2, 1'b0, 1'b0};
      tbl[10] = '{4'h0, 4'hF, 4'd15, 4'd0,  3,     -3, 2044, 1'b0, 1'b0};
      tbl[11] = '{4'h1, 4'h0, 4'd3,  4'd0,  5,      5,    0, 1'b0, 1'b0};
      tbl[12] = '{4'hF, 4'hF, 4'd3,  4'd2,  2,      0,    0, 1'b0, 1'b0};
      tbl[13] = '{4'h1, 4'h2, 4'd3,  4'd2,  1,      0,    0, 1'b0, 1'b0};

      // Reset with random inputs: everything reads zero.
      up = 4'($urandom); dn = 4'($urandom);
      kp = 4'($urandom); ki = 4'($urandom);
      clr_sat = 1'($urandom);
      #3;
      check("rst_code", longint'(code), 0);
      check("rst_freq", longint'(freq_out), 0);
      check("rst_upd", longint'(upd_valid), 0);
      check("rst_locked", longint'(locked), 0);
      check("rst_sat", longint'(sat_flag), 0);
      model_reset();

      // First update lands on the fifth edge after release.
      kp = 4'd3; ki = 4'd2; mode = 2'd0; clr_sat = 1'b0;
      up = 4'hF; dn = 4'h0;
      do_reset();
      for (int e = 1; e <= 5; e++) begin
         cyc();
         check($sformatf("first_upd_e%0d", e), longint'(upd_valid), longint'(e == 5));
      end
      check("first_freq", longint'(freq_out), 4);
      count_to_upd(n);
      check("second_upd_gap", n, 4);
      check("second_freq", longint'(freq_out), 8);

      // Table vectors, each from a fresh reset.
      foreach (tbl[i]) begin
         up = tbl[i].up; dn = tbl[i].dn; kp = tbl[i].kp; ki = tbl[i].ki;
         mode = 2'd0; clr_sat = 1'b0;
         do_reset();
         n = 0;
         for (int c = 0; c < 400 && n < tbl[i].windows; c++) begin
            cyc();
            if (upd_valid) n++;
         end
         check($sformatf("tbl%0d_windows", i), n, tbl[i].windows);
         cyc();
         check($sformatf("tbl%0d_freq", i), longint'(freq_out), tbl[i].exp_freq);
         check($sformatf("tbl%0d_code", i), longint'(code), tbl[i].exp_code);
         check($sformatf("tbl%0d_locked", i), longint'(locked), longint'(tbl[i].exp_locked));
         check($sformatf("tbl%0d_sat", i), longint'(sat_flag), longint'(tbl[i].exp_sat));
      end

      // Freeze mid-window: nothing moves, partial window dropped on return.
      kp = 4'd3; ki = 4'd2; mode = 2'd0; up = 4'hF; dn = 4'h0;
      do_reset();
      count_to_upd(n);
      check("frz_pre_upd", n, 5);
      up = 4'h0; dn = 4'hF;
      cyc(); cyc();
      mode = 2'd2; up = 4'hF; dn = 4'h0;
      for (int c = 0; c < 10; c++) begin
         cyc();
         check("frz_upd", longint'(upd_valid), 0);
         check("frz_freq", longint'(freq_out), 4);
      end
      mode = 2'd0;
      count_to_upd(n);
      check("frz_return_edges", n, 5);
      check("frz_return_freq", longint'(freq_out), 8);

      // Mode 3 is also a freeze.
      mode = 2'd3;
      for (int c = 0; c < 6; c++) begin
         cyc();
         check("frz3_upd", longint'(upd_valid), 0);
      end
      mode = 2'd0;

      // Reset mid-window after three updates.
      do_reset();
      count_to_upd(n);
      check("rst_seq_upd1", n, 5);
      count_to_upd(n);
      check("rst_seq_upd2", n, 4);
      count_to_upd(n);
      check("rst_seq_upd3", n, 4);
      check("rst_seq_freq3", longint'(freq_out), 12);
      cyc(); cyc();
      do_reset();
      check("rst_mid_freq", longint'(freq_out), 0);
      check("rst_mid_code", longint'(code), 0);
      check("rst_mid_upd", longint'(upd_valid), 0);
      count_to_upd(n);
      check("rst_mid_first_upd", n, 5);
      check("rst_mid_freq4", longint'(freq_out), 4);

      // Randomized traffic against the model.
      bias = 0;
      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) bias = $urandom_range(0, 2);
         if (c % 40 == 0) begin
            kp = 4'($urandom);
            ki = 4'($urandom);
         end
         if (c % 25 == 0) begin
            r = $urandom_range(0, 9);
            mode = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : 2'($urandom_range(2, 3));
         end
         up = 4'($urandom);
         dn = 4'($urandom);
         if (bias == 1) begin
            up = up | 4'hE;
            dn = dn & 4'h1;
         end else if (bias == 2) begin
            dn = dn | 4'hE;
            up = up & 4'h1;
         end
         clr_sat = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 999) == 0) do_reset();
         else cyc();
      end
      clr_sat = 1'b0;

      // Long constant-up run: frequency clamps, code wraps (large kp makes
      // the phase wrap well within the run), then clr_sat clears the flag.
      kp = 4'd14; ki = 4'd2; mode = 2'd0; up = 4'hF; dn = 4'h0;
      do_reset();
      nwin = 0; prev_code = 0; wrapped = 0;
      for (int c = 0; c < 40000 && nwin < 8200; c++) begin
         cyc();
         if (upd_valid) nwin++;
         if (int'(code) < prev_code) wrapped = 1;
         prev_code = int'(code);
      end
      check("sat_windows", nwin, 8200);
      check("sat_freq", longint'(freq_out), 32767);
      check("sat_flag_set", longint'(sat_flag), 1);
      check("code_wrapped", longint'(wrapped), 1);
      clr_sat = 1'b1;
      cyc();
      clr_sat = 1'b0;
      check("sat_cleared", longint'(sat_flag), 0);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cdr_loop_filter.md
CDR_LOOP_FILTER -- requirements
Module: cdr_loop_filter

Interface
REQ-001 SHALL have parameter NUM_PD, default 4: number of phase-detector Up/Dn lane pairs.
REQ-002 SHALL have parameter DEC_LEN, default 4: vote cycles per integrator update.
REQ-003 SHALL have parameters FREQ_WIDTH 16, PHASE_WIDTH 25, CODE_WIDTH 11, FSHIFT 6 and LOCK_CNT 64.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 up, dn  in  NUM_PD each  per-lane early/late indications.
REQ-007 kp, ki  in  4 each  proportional and integral gain shifts; gain = 1<<kp, 1<<ki.
REQ-008 mode  in  2  0 = second-order, 1 = first-order (freq held), 2 = freeze, 3 = same as 2.
REQ-009 clr_sat  in  1  clears sat_flag.
REQ-010 code  out  CODE_WIDTH  phase-interpolator code = phase[PHASE_WIDTH-1 -: CODE_WIDTH].
REQ-011 freq_out  out  FREQ_WIDTH  signed frequency integrator.
REQ-012 upd_valid, locked, sat_flag  out  1 each  update pulse, lock status, sticky saturation.

Function
REQ-013 Lane vote: up&~dn = +1, dn&~up = -1, both or neither = 0; vote = signed sum over lanes, registered into vote_q (stage 1).
REQ-014 Window: signed accumulator sums vote_q; win_cnt counts 0..DEC_LEN-1; width sized for ±NUM_PD*DEC_LEN.
REQ-015 On the edge where win_cnt == DEC_LEN-1: d = sign(acc + vote_q) in {-1,0,+1}; acc and win_cnt cleared; integrators update; upd_valid = 1 for exactly that following cycle.
REQ-016 Latency with DEC_LEN = 1: Up/Dn stable before edge k -> vote_q at k -> code/freq_out at k+1.
REQ-017 Mode 0: freq <= sat(freq + d*(1<<ki)), signed, clamped to [-2^(FREQ_WIDTH-1), 2^(FREQ_WIDTH-1)-1].
REQ-018 phase <= phase + sext(freq_old >>> FSHIFT) + d*(1<<kp), modulo 2^PHASE_WIDTH (wraps, no flag); freq_old is the value before the same-edge update.
REQ-019 Mode 1: freq holds; phase updates per REQ-018.
REQ-020 Mode 2/3: vote_q still registers; acc, win_cnt cleared and held; freq, phase, lock counter hold; upd_valid = 0.
REQ-021 Mode changes take effect at the next edge; a partial window is discarded when entering freeze.
REQ-022 sat_flag sets on any update where clamping occurs; clr_sat clears it; set wins over simultaneous clear.
REQ-023 Lock counter: increments on update if d == 0 or d == -prev_d; resets to 0 if d == prev_d != 0; saturates at LOCK_CNT; prev_d updates on every nonzero d.
REQ-024 locked = (lock counter == LOCK_CNT), registered.
REQ-025 kp, ki >= FREQ_WIDTH-1 SHALL be treated as FREQ_WIDTH-2.

Reset
REQ-026 rst_n low asynchronously clears vote_q, acc, win_cnt, freq, phase, prev_d, lock counter and all outputs to 0.
REQ-027 Reset mid-window discards the partial window; first update after release occurs after a full DEC_LEN window.

Structure
REQ-028 Package cdr_lf_pkg holds the mode enum (LF_2ND, LF_1ST, LF_FREEZE) and default parameter constants.
REQ-029 One sub-module, cdr_lf_vote, SHALL implement the lane vote popcount and vote_q register; integrators, lock and saturation logic stay in the top.
REQ-030 No DPI or behavioural-only constructs; fully synthesizable.

Verification (defaults; kp=3, ki=2, mode 0)
REQ-031 Reset with random inputs -> code, freq_out, upd_valid, locked, sat_flag all 0.
REQ-032 up=4'hF, dn=0 -> first upd_valid after 5 edges: freq=4, phase=8; second window: freq=8, phase=16.
REQ-033 up=4'b0011, dn=4'b1100 (vote 0) -> upd_valid every 4 cycles, freq/phase unchanged, locked=1 after 64 windows.
REQ-034 Constant up for >8192 windows -> freq clamps at 32767, sat_flag=1; code wraps 2047->0 with no flag; clr_sat -> sat_flag=0.
REQ-035 mode=2 asserted mid-window, held 10 cycles, then mode=0 -> no upd_valid while frozen, state held; next update exactly 5 edges after return.
REQ-036 rst_n pulsed mid-window after 3 updates -> all state 0 immediately; first update 5 edges after release.
